// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decode, 16x32 regfile read with writeback bypass, busy scoreboard, registered ALU operands
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        instruction handshake; in_instr = {sel,imm_en,rd,rs,rt,imm15}
//   flush                    drop held op and clear scoreboard
//   wb_en/wb_addr/wb_data    ALU result writeback into the regfile
//   out_valid/out_ready      issued-op handshake toward the ALU
//   A, B, sel, rd            registered operands, function select and destination tag
module alu_operand_stage #(
   parameter int DATA_W     = 32,
   parameter bit IMM_SIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [3:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [3:0]        sel,
   output logic [3:0]        rd
);
   logic [DATA_W-1:0] rf_q [16];
   logic [15:0]       busy_q, busy_d, busy_eff, wb_mask, rd_mask;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] a_q, b_q, a_d, b_d, imm_ext;
   logic [3:0]        sel_q, rd_q;
   logic [3:0]        i_sel, i_rd, i_rs, i_rt;
   logic              i_imm_en, wb_hit, hz, accept;
   logic [14:0]       imm15;

   assign {i_sel, i_imm_en, i_rd, i_rs, i_rt, imm15} = in_instr;
   assign imm_ext = IMM_SIGNED ? {{(DATA_W-15){imm15[14]}}, imm15} : {{(DATA_W-15){1'b0}}, imm15};

   // R0 is hardwired to zero; a same-cycle writeback to the read register is forwarded
   assign wb_hit = wb_en && wb_addr != 4'd0;
   assign a_d = i_rs == 4'd0 ? '0 : (wb_hit && wb_addr == i_rs) ? wb_data : rf_q[i_rs];
   assign b_d = i_imm_en ? imm_ext :
                i_rt == 4'd0 ? '0 : (wb_hit && wb_addr == i_rt) ? wb_data : rf_q[i_rt];

   // a register being written back this cycle is no longer a hazard; busy_q[0] is never set
   assign wb_mask  = wb_hit ? 16'd1 << wb_addr : 16'd0;
   assign busy_eff = busy_q & ~wb_mask;
   assign hz       = busy_eff[i_rs] | (!i_imm_en & busy_eff[i_rt]) | busy_eff[i_rd];

   assign in_ready = rst_n & !flush & !hz & (!out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   // the issue-side set is OR-ed after the writeback clear so it wins on the same register
   assign rd_mask     = (accept && i_rd != 4'd0) ? 16'd1 << i_rd : 16'd0;
   assign busy_d      = flush ? 16'd0 : busy_eff | rd_mask;
   assign out_valid_d = accept | (out_valid_q & !out_ready & !flush);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) rf_q[i] <= '0;
         busy_q      <= '0;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         rd_q        <= '0;
      end else begin
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         if (wb_hit) rf_q[wb_addr] <= wb_data;
         if (accept) begin
            a_q   <= a_d;
            b_q   <= b_d;
            sel_q <= i_sel;
            rd_q  <= i_rd;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign A         = a_q;
   assign B         = b_q;
   assign sel       = sel_q;
   assign rd        = rd_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vector table plus randomized run against a behavioural model
module tb_alu_operand_stage;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, wb_en = 1'b0, out_ready = 1'b0;
   logic [31:0] in_instr = '0, wb_data = '0;
   logic [3:0]  wb_addr = '0;
   logic        in_ready, out_valid, in_ready_u, out_valid_u;
   logic [31:0] A, B, A_u, B_u;
   logic [3:0]  sel, rd, sel_u, rd_u;
   int errs = 0, checks = 0;

   alu_operand_stage #(.DATA_W(32), .IMM_SIGNED(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B), .sel(sel), .rd(rd));

   alu_operand_stage #(.DATA_W(32), .IMM_SIGNED(1'b0)) dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u), .in_instr(in_instr),
      .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid_u), .out_ready(out_ready), .A(A_u), .B(B_u), .sel(sel_u), .rd(rd_u));

   always #5 clk = ~clk;

   // behavioural model: architectural registers, in-flight destination set, held output
   logic [31:0] m_r [16];
   bit          m_busy [16];
   bit          m_ov;
   logic [31:0] m_a, m_b;
   logic [3:0]  m_sel, m_rd;

   typedef struct {
      bit wbe; logic [3:0] wba; logic [31:0] wbd; bit iv; logic [31:0] ins; bit ordy; bit fl;
      bit e_rdy; bit e_ov; logic [31:0] e_a; logic [31:0] e_b; logic [3:0] e_sel; logic [3:0] e_rd;
   } vec_t;
   vec_t tbl [21];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input int s, input int ie, input int d, input int rs, input int rt, input int imm);
      return {4'(s), 1'(ie), 4'(d), 4'(rs), 4'(rt), 15'(imm)};
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_r[i] = 0;
         m_busy[i] = 0;
      end
      m_ov = 0; m_a = 0; m_b = 0; m_sel = 0; m_rd = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [3:0] x);
      if (x == 0) return 0;
      if (wb_en && wb_addr == x) return wb_data;
      return m_r[x];
   endfunction

   function automatic bit m_pending(input logic [3:0] x);
      return x != 0 && m_busy[x] && !(wb_en && wb_addr == x);
   endfunction

   task automatic model_cycle(output bit rdy);
      logic [3:0]  s, d, rs, rt;
      bit          ie, acc;
      logic [14:0] imm;
      {s, ie, d, rs, rt, imm} = in_instr;
      rdy = rst_n && !flush && !(m_pending(rs) || (!ie && m_pending(rt)) || m_pending(d)) && (!m_ov || out_ready);
      acc = in_valid && rdy;
      if (acc) begin
         m_a = m_read(rs);
         m_b = ie ? 32'(signed'(imm)) : m_read(rt);
         m_sel = s;
         m_rd = d;
      end
      if (wb_en && wb_addr != 0) begin
         m_r[wb_addr] = wb_data;
         m_busy[wb_addr] = 0;
      end
      if (flush) for (int i = 0; i < 16; i++) m_busy[i] = 0;
      if (acc && d != 0) m_busy[d] = 1;
      m_ov = flush ? 0 : acc ? 1 : out_ready ? 0 : m_ov;
   endtask

   task automatic step(output bit rdy_exp, output bit rdy_act);
      @(negedge clk);
      rdy_act = in_ready;
      model_cycle(rdy_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_ov"}, 32'(out_valid), 32'(m_ov));
      chk({tag, "_A"}, A, m_a);
      chk({tag, "_B"}, B, m_b);
      chk({tag, "_sel"}, 32'(sel), 32'(m_sel));
      chk({tag, "_rd"}, 32'(rd), 32'(m_rd));
   endtask

   initial begin
      bit re, ra;
      tbl[0]  = '{1, 1, 150, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 2, 78, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 0, 0, 1, mk(3, 0, 3, 1, 2, 0), 1, 0, 1, 1, 150, 78, 3, 3};
      tbl[3]  = '{0, 0, 0, 1, mk(5, 1, 4, 1, 0, 'h7FFE), 1, 0, 1, 1, 150, 32'hFFFFFFFE, 5, 4};
      tbl[4]  = '{0, 0, 0, 1, mk(1, 0, 6, 3, 0, 0), 1, 0, 0, 0, 150, 32'hFFFFFFFE, 5, 4};
      tbl[5]  = '{1, 3, 228, 1, mk(1, 0, 6, 3, 0, 0), 1, 0, 1, 1, 228, 0, 1, 6};
      for (int i = 6; i < 10; i++) tbl[i] = '{0, 0, 0, 1, mk(2, 0, 7, 1, 2, 0), 0, 0, 0, 1, 228, 0, 1, 6};
      tbl[10] = '{0, 0, 0, 1, mk(2, 0, 7, 1, 2, 0), 1, 0, 1, 1, 150, 78, 2, 7};
      tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 150, 78, 2, 7};
      tbl[12] = '{0, 0, 0, 1, mk(0, 0, 5, 0, 0, 0), 1, 0, 1, 1, 0, 0, 0, 5};
      tbl[13] = '{1, 0, 'hDEAD, 1, mk(0, 0, 8, 5, 0, 0), 1, 1, 0, 0, 0, 0, 0, 5};
      tbl[14] = '{0, 0, 0, 1, mk(9, 0, 8, 5, 0, 0), 1, 0, 1, 1, 0, 0, 9, 8};
      tbl[15] = '{0, 0, 0, 1, mk(4, 0, 9, 0, 0, 0), 1, 0, 1, 1, 0, 0, 4, 9};
      tbl[16] = '{1, 10, 'h1234, 1, mk(7, 0, 10, 10, 10, 0), 1, 0, 1, 1, 'h1234, 'h1234, 7, 10};
      tbl[17] = '{0, 0, 0, 1, mk(1, 0, 10, 1, 0, 0), 1, 0, 0, 0, 'h1234, 'h1234, 7, 10};
      tbl[18] = '{1, 10, 5, 1, mk(1, 0, 10, 0, 0, 0), 1, 0, 1, 1, 0, 0, 1, 10};
      tbl[19] = '{0, 0, 0, 1, mk(1, 0, 11, 10, 0, 0), 1, 0, 0, 0, 0, 0, 1, 10};
      tbl[20] = '{1, 10, 77, 1, mk(1, 0, 11, 10, 0, 0), 1, 0, 1, 1, 77, 0, 1, 11};

      m_reset();
      repeat (5) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_ov_low", 32'(out_valid), 0);
      rst_n = 1'b1;
      #1;
      chk("rst_rel_ready", 32'(in_ready), 1);
      chk("rst_ov", 32'(out_valid), 0);
      chk("rst_A", A, 0);
      chk("rst_B", B, 0);

      for (int i = 0; i < 21; i++) begin
         {wb_en, wb_addr, wb_data, in_valid, in_instr, out_ready, flush} =
            {tbl[i].wbe, tbl[i].wba, tbl[i].wbd, tbl[i].iv, tbl[i].ins, tbl[i].ordy, tbl[i].fl};
         step(re, ra);
         chk($sformatf("v%0d_ready", i), 32'(ra), 32'(tbl[i].e_rdy));
         chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("v%0d_A", i), A, tbl[i].e_a);
         chk($sformatf("v%0d_B", i), B, tbl[i].e_b);
         chk($sformatf("v%0d_sel", i), 32'(sel), 32'(tbl[i].e_sel));
         chk($sformatf("v%0d_rd", i), 32'(rd), 32'(tbl[i].e_rd));
         if (i == 3) chk("imm_zext_B", B_u, 32'h00007FFE);
      end

      for (int n = 0; n < 1500; n++) begin
         in_valid  = ($urandom % 4) != 0;
         in_instr  = {4'($urandom), 1'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                      4'($urandom_range(0, 7)), 15'($urandom)};
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 40) == 0;
         wb_en     = 1'($urandom);
         wb_addr   = 4'($urandom_range(0, 7));
         wb_data   = $urandom;
         step(re, ra);
         chk($sformatf("r%0d_ready", n), 32'(ra), 32'(re));
         chk_model($sformatf("r%0d", n));
      end

      // async reset while an op is held
      {wb_en, flush, out_ready, in_valid} = 4'b0001;
      in_instr = mk(6, 1, 0, 0, 0, 1);
      step(re, ra);
      chk("pre_rst_ov", 32'(out_valid), 32'(m_ov));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ov", 32'(out_valid), 0);
      chk("arst_A", A, 0);
      chk("arst_in_ready", 32'(in_ready), 0);
      m_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      in_valid = 1'b1;
      in_instr = mk(3, 0, 2, 1, 0, 0);
      step(re, ra);
      chk("post_rst_ready", 32'(ra), 1);
      chk("post_rst_ov", 32'(out_valid), 1);
      chk("post_rst_sel", 32'(sel), 3);
      chk("post_rst_rd", 32'(rd), 2);
      chk("post_rst_A", A, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
